// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared constants helper for clock dividers
package clkdiv_pkg;

    // Divisor rounded to nearest; zero denominators yield 0 so elaboration checks can trip.
    function automatic int unsigned div_round(input longint unsigned f0, input longint unsigned f1);
        longint unsigned q;
        if (f1 == 0) begin
            return 0;
        end
        q = (f0 + f1 / 2) / f1;
        return int'(q);
    endfunction

    function automatic int unsigned cw_of(input int unsigned div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/clkdiv.sv
// rtl/clkdiv.sv - integer clock divider with registered square-wave output
module clkdiv
    import clkdiv_pkg::*;
#(
    parameter int unsigned F_0 = 50_000_000,
    parameter int unsigned F_1 = 9_600
) (
    input  logic clk,
    input  logic rst_n,
    output logic out
);

    localparam int unsigned DIV  = div_round(F_0, F_1);
    localparam int unsigned LOW  = DIV / 2;
    localparam int unsigned HIGH = DIV - LOW;
    localparam int unsigned CW   = cw_of(DIV);

    localparam logic [CW-1:0] LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] LOW_C = CW'(LOW);

    if (F_0 == 0 || F_1 == 0) begin : g_bad_freq
        $fatal(1, "clkdiv: F_0 and F_1 must be positive");
    end
    if (DIV < 2 || F_1 > F_0 / 2) begin : g_bad_div
        $fatal(1, "clkdiv: F_1 must not exceed F_0/2 (divisor below 2)");
    end

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    assign cnt_next = (cnt == LAST) ? '0 : cnt + 1'b1;

    // out is derived from the next count so it is registered alongside cnt, never decoded combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            out <= 1'b0;
        end else begin
            cnt <= cnt_next;
            out <= (cnt_next >= LOW_C);
        end
    end

    logic unused_high;
    assign unused_high = ^HIGH[0];

endmodule

// File: tb/tb_clkdiv.sv
// tb/tb_clkdiv.sv - directed self-checking bench for clkdiv
module tb_clkdiv;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic out_a, out_b, out_c, out_d, out_e;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // DIV=5, LOW=2
    clkdiv #(.F_0(10), .F_1(2)) u_a (.clk(clk), .rst_n(rst_n), .out(out_a));
    // DIV=434, LOW=217
    clkdiv #(.F_0(50_000_000), .F_1(115_200)) u_b (.clk(clk), .rst_n(rst_n), .out(out_b));
    // DIV=5208, LOW=2604
    clkdiv #(.F_0(50_000_000), .F_1(9_600)) u_c (.clk(clk), .rst_n(rst_n), .out(out_c));
    // DIV=1302, LOW=651
    clkdiv #(.F_0(50_000_000), .F_1(38_400)) u_d (.clk(clk), .rst_n(rst_n), .out(out_d));
    // DIV=2, LOW=1
    clkdiv #(.F_0(2), .F_1(1)) u_e (.clk(clk), .rst_n(rst_n), .out(out_e));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic exp_out(input int k, input int div, input int low);
        return (k % div) >= low;
    endfunction

    task automatic check_all(input int k);
        check($sformatf("a_k%0d", k), 32'(out_a), 32'(exp_out(k, 5, 2)));
        check($sformatf("b_k%0d", k), 32'(out_b), 32'(exp_out(k, 434, 217)));
        check($sformatf("c_k%0d", k), 32'(out_c), 32'(exp_out(k, 5208, 2604)));
        check($sformatf("d_k%0d", k), 32'(out_d), 32'(exp_out(k, 1302, 651)));
        check($sformatf("e_k%0d", k), 32'(out_e), 32'(exp_out(k, 2, 1)));
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // phase-length monitor for the 434 divider
    logic mon_en = 1'b0;
    logic prev_b = 1'b0;
    int   run_len = 0;
    int   runs_seen = 0;

    initial begin
        int  k;
        int  waited;
        logic [4:0] snap;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_a", 32'(out_a), 32'd0);
        check("reset_all", 32'({out_a, out_b, out_c, out_d, out_e}), 32'd0);

        release_reset();
        mon_en = 1'b1;
        for (k = 1; k <= 25000; k++) begin
            @(posedge clk);
            #1;
            check_all(k);
            if (k == 5207) begin
                snap = {out_b, out_c, out_d, 2'b00};
                check("all_high_5207", 32'(snap), 32'b11100);
            end
            if (k == 5208) begin
                snap = {out_b, out_c, out_d, 2'b00};
                check("all_fall_5208", 32'(snap), 32'b00000);
            end
        end
        mon_en = 1'b0;
        check("b_runs_counted", 32'(runs_seen > 100), 32'd1);

        // async reset in the middle of a high phase of u_a
        waited = 0;
        while (out_a !== 1'b1 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("a_high_before_rst", 32'(out_a), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_a", 32'(out_a), 32'd0);
        check("async_rst_all", 32'({out_a, out_b, out_c, out_d, out_e}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("held_rst_all", 32'({out_a, out_b, out_c, out_d, out_e}), 32'd0);

        release_reset();
        for (k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            check_all(k);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    always @(posedge clk) begin
        if (mon_en) begin
            #1;
            if (out_b !== prev_b) begin
                if (runs_seen > 0) begin
                    check($sformatf("b_phase%0d", runs_seen), 32'(run_len), 32'd217);
                end
                runs_seen++;
                run_len = 1;
                prev_b = out_b;
            end else begin
                run_len++;
            end
        end
    end

endmodule

// File: doc/clkdiv.md
Name: clkdiv

Overview:
- Parameterised integer clock divider.
- Derives a square-wave output at approximately F_1 Hz from a reference clock of F_0 Hz, for example UART baud ticks of 9600, 38400 or 115200 from 50 MHz.
- Purely synchronous counter with a registered, glitch-free output.
- Intended to drive enables or slow clocks in peripheral blocks; several instances with different F_1 may share one clk and rst_n.

Parameters:
- F_0, default 50_000_000: input clock frequency in Hz (integer, >0).
- F_1, default 9_600: desired output frequency in Hz (integer, >0, F_1 <= F_0/2).

Ports:
- clk  input  1  reference clock at F_0; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- out  output  1  divided clock, period DIV clk cycles, registered.

Behaviour:
- Derived localparams:
  - DIV = (F_0 + F_1/2) / F_1, integer division, rounded to nearest. Examples: 50M/9600 -> 5208; 50M/38400 -> 1302; 50M/115200 -> 434.
  - LOW = DIV/2 (floor).
  - HIGH = DIV - LOW. For odd DIV the extra cycle is high.
  - CW = max(1, $clog2(DIV)).
- Elaboration checks (fatal error):
  - F_0 > 0 and F_1 > 0.
  - DIV >= 2.
- State:
  - cnt: unsigned, CW bits, range 0..DIV-1.
  - out: 1-bit register.
- Reset (rst_n low, asynchronous, takes effect immediately regardless of clk):
  - cnt = 0, out = 0.
  - Held for as long as rst_n is low.
- Each rising clk edge with rst_n high:
  - cnt_next = (cnt == DIV-1) ? 0 : cnt+1; cnt <= cnt_next.
  - out <= (cnt_next >= LOW).
- Resulting waveform after reset release:
  - Edges 1..LOW-1: out stays 0.
  - out rises at edge LOW and stays high for HIGH cycles.
  - out falls at edge DIV.
  - Thereafter strictly periodic: period DIV cycles, LOW cycles low, HIGH cycles high.
- Duty cycle is exactly 50% for even DIV. For odd DIV, high is one cycle longer than low.
- Wrap-around: cnt returns from DIV-1 to 0 with no skipped or duplicated cycle. out changes only on clk edges, never combinationally.
- Reset mid-period: out drops to 0 and cnt to 0 asynchronously. After release the sequence restarts exactly as from power-up.
- Frequency error is the rounding error of DIV only. No fractional accumulation.
- Multiple instances released from the same reset are phase-aligned at cnt=0.

Decomposition:
- No shared package required. DIV, LOW, HIGH and CW are local to the module.
- If the team keeps a common utilities package, a constant function computing the rounded divisor may live there.
- No sub-module; single always_ff block plus localparams.

Test Plan:
- F_0=10, F_1=2 (DIV=5, LOW=2, HIGH=3): pulse rst_n low, release. out = 0 after reset; rises at edge 2 after release, falls at edge 5; repeating period 5 with 3 high / 2 low.
- F_0=50_000_000, F_1=115_200 (DIV=434): over 25000 clk cycles, every high and low phase is exactly 217 cycles and every period is exactly 434 cycles.
- Three instances with F_1 = 9600, 38400 and 115200 on a shared clk and rst_n: periods 5208, 1302 and 434 cycles; all out fall together at cycle 5208 after release.
- Assert rst_n low mid-high-phase (async, between clk edges): out goes 0 immediately. After release the first rising edge of out occurs exactly LOW edges later.
- Minimum divisor F_0=2, F_1=1 (DIV=2): out toggles every clk edge after release (0,1,0,1...).
- Elaboration: F_1 > F_0/2 (e.g. F_0=10, F_1=8) must fail elaboration with a fatal message.
